// File: rtl/noc_input_arbiter.sv
// Round-robin arbiter that merges NUM_SRC valid/ready word sources into a tagged FIFO,
// drained and controlled by a Nios master through an Avalon-MM slave (1-cycle read latency).
module noc_input_arbiter #(
  parameter int NUM_SRC    = 4,
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_SRC-1:0]        src_valid,
  input  logic [NUM_SRC*DATA_W-1:0] src_data,
  output logic [NUM_SRC-1:0]        src_ready,
  input  logic [1:0]                address,
  input  logic                      read,
  input  logic                      write,
  input  logic [31:0]               writedata,
  output logic [31:0]               readdata,
  output logic                      irq
);

  localparam int SRC_W = $clog2(NUM_SRC);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [1:0] ADDR_DATA    = 2'd0;
  localparam logic [1:0] ADDR_STATUS  = 2'd1;
  localparam logic [1:0] ADDR_CONTROL = 2'd2;

  typedef struct packed {
    logic [SRC_W-1:0]  src;
    logic [DATA_W-1:0] data;
  } entry_t;

  entry_t               mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic [SRC_W-1:0]     last_q, last_d;
  logic [NUM_SRC-1:0]   enable_mask_q, enable_mask_d;
  logic                 irq_en_q, irq_en_d;
  logic [31:0]          readdata_q, readdata_d;
  logic                 irq_q, irq_d;

  logic                 fifo_empty, fifo_full;
  logic [NUM_SRC-1:0]   eligible;
  logic [NUM_SRC-1:0]   grant;
  logic [SRC_W-1:0]     grant_idx;
  logic                 grant_found;
  int                   cand;
  logic [DATA_W-1:0]    push_data;
  entry_t               push_entry;
  entry_t               head;
  logic                 push, pop;
  logic                 unused_wdata;

  assign fifo_empty   = (count_q == '0);
  assign fifo_full    = (count_q == CNT_W'(FIFO_DEPTH));
  assign eligible     = src_valid & enable_mask_q;
  assign head         = mem_q[rd_ptr_q];
  assign unused_wdata = ^writedata;

  // Round-robin search starting just after the last granted source.
  // NOTE: every signal written in an always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    grant       = '0;
    grant_idx   = '0;
    grant_found = 1'b0;
    cand        = 0;
    if (!fifo_full) begin
      for (int k = 1; k <= NUM_SRC; k++) begin
        cand = int'(last_q) + k;
        if (cand >= NUM_SRC) cand = cand - NUM_SRC;
        if (!grant_found && eligible[SRC_W'(cand)]) begin
          grant_found           = 1'b1;
          grant[SRC_W'(cand)]   = 1'b1;
          grant_idx             = SRC_W'(cand);
        end
      end
    end
  end

  always_comb begin
    push_data = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (grant[i]) push_data = src_data[i*DATA_W +: DATA_W];
    end
  end

  assign src_ready       = grant;
  assign push            = grant_found;
  assign push_entry.src  = grant_idx;
  assign push_entry.data = push_data;
  // Popping an empty FIFO is a no-op, even if a word is pushed on the same edge.
  assign pop             = read && (address == ADDR_DATA) && !fifo_empty;

  always_comb begin
    wr_ptr_d      = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d      = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d       = count_q;
    if (push && !pop) count_d = count_q + CNT_W'(1);
    if (!push && pop) count_d = count_q - CNT_W'(1);
    last_d        = push ? grant_idx : last_q;
    enable_mask_d = enable_mask_q;
    irq_en_d      = irq_en_q;
    if (write && (address == ADDR_CONTROL)) begin
      enable_mask_d = writedata[NUM_SRC-1:0];
      irq_en_d      = writedata[8];
    end
    irq_d = irq_en_q & !fifo_empty;
  end

  // Read mux; all fields reflect state at the start of the read cycle.
  always_comb begin
    readdata_d = readdata_q;
    if (read) begin
      readdata_d = '0;
      case (address)
        ADDR_DATA: begin
          if (!fifo_empty) readdata_d = head.data;
        end
        ADDR_STATUS: begin
          readdata_d[0]    = fifo_empty;
          readdata_d[1]    = fifo_full;
          readdata_d[7:4]  = 4'(count_q);
          readdata_d[10:8] = fifo_empty ? 3'd0 : 3'(head.src);
        end
        ADDR_CONTROL: begin
          readdata_d[NUM_SRC-1:0] = enable_mask_q;
          readdata_d[8]           = irq_en_q;
        end
        default: readdata_d = '0;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      last_q        <= SRC_W'(NUM_SRC - 1);
      enable_mask_q <= '0;
      irq_en_q      <= 1'b0;
      readdata_q    <= '0;
      irq_q         <= 1'b0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      last_q        <= last_d;
      enable_mask_q <= enable_mask_d;
      irq_en_q      <= irq_en_d;
      readdata_q    <= readdata_d;
      irq_q         <= irq_d;
    end
  end

  // NOTE: the storage array is not reset; count_q gates every read, so stale entries are never visible.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= push_entry;
  end

  assign readdata = readdata_q;
  assign irq      = irq_q;

endmodule

// File: tb/tb_noc_input_arbiter.sv
// Self-checking bench for noc_input_arbiter: a reference model predicts grants and
// queues expected FIFO entries, which are popped and compared on DATA reads.
module tb_noc_input_arbiter;

  localparam int NUM_SRC    = 4;
  localparam int DATA_W     = 32;
  localparam int FIFO_DEPTH = 4;

  logic                      clk = 1'b0;
  logic                      reset = 1'b1;
  logic [NUM_SRC-1:0]        src_valid = '0;
  logic [NUM_SRC*DATA_W-1:0] src_data = '0;
  logic [NUM_SRC-1:0]        src_ready;
  logic [1:0]                address = '0;
  logic                      read = 1'b0;
  logic                      write = 1'b0;
  logic [31:0]               writedata = '0;
  logic [31:0]               readdata;
  logic                      irq;

  noc_input_arbiter #(
    .NUM_SRC   (NUM_SRC),
    .DATA_W    (DATA_W),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .src_valid(src_valid),
    .src_data (src_data),
    .src_ready(src_ready),
    .address  (address),
    .read     (read),
    .write    (write),
    .writedata(writedata),
    .readdata (readdata),
    .irq      (irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  src;
    logic [31:0] data;
  } ent_t;

  ent_t        sb_q[$];
  logic [3:0]  m_mask;
  logic        m_irq_en;
  int          m_last;
  logic [31:0] m_rdata;
  int          n_checks = 0;
  int          n_fail   = 0;
  int          word_cnt = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [3:0] model_grant();
    int idx;
    if (sb_q.size() >= FIFO_DEPTH) return 4'b0;
    for (int k = 1; k <= NUM_SRC; k++) begin
      idx = (m_last + k) % NUM_SRC;
      if (src_valid[idx] && m_mask[idx]) return 4'(1 << idx);
    end
    return 4'b0;
  endfunction

  function automatic logic [31:0] model_status();
    logic [31:0] s;
    s       = '0;
    s[0]    = (sb_q.size() == 0);
    s[1]    = (sb_q.size() == FIFO_DEPTH);
    s[7:4]  = 4'(sb_q.size());
    s[10:8] = (sb_q.size() == 0) ? 3'd0 : sb_q[0].src;
    return s;
  endfunction

  function automatic void model_reset();
    sb_q.delete();
    m_mask   = '0;
    m_irq_en = 1'b0;
    m_last   = NUM_SRC - 1;
    m_rdata  = '0;
  endfunction

  // Give every source a fresh, distinct word.
  task automatic fresh_data();
    for (int i = 0; i < NUM_SRC; i++) begin
      word_cnt++;
      src_data[i*DATA_W +: DATA_W] = 32'hC000_0000 | (32'(i) << 24) | 32'(word_cnt);
    end
  endtask

  // One clock: predict and check grant at negedge, update the model, check registered outputs after the edge.
  task automatic step();
    logic [3:0] g;
    logic       exp_irq;
    int         idx;
    ent_t       e;
    @(negedge clk);
    g = model_grant();
    check("src_ready", 32'(src_ready), 32'(g));
    exp_irq = m_irq_en && (sb_q.size() != 0);
    if (read) begin
      case (address)
        2'd0: begin
          if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            m_rdata = e.data;
          end else begin
            m_rdata = '0;
          end
        end
        2'd1: m_rdata = model_status();
        2'd2: m_rdata = {23'b0, m_irq_en, 4'b0, m_mask};
        default: m_rdata = '0;
      endcase
    end
    if (g != 0) begin
      idx = 0;
      for (int i = 0; i < NUM_SRC; i++) if (g[i]) idx = i;
      e.src  = 3'(idx);
      e.data = src_data[idx*DATA_W +: DATA_W];
      sb_q.push_back(e);
      m_last = idx;
    end
    if (write && address == 2'd2) begin
      m_mask   = writedata[3:0];
      m_irq_en = writedata[8];
    end
    @(posedge clk);
    #1;
    read  = 1'b0;
    write = 1'b0;
    check("readdata", readdata, m_rdata);
    check("irq", 32'(irq), 32'(exp_irq));
  endtask

  task automatic reg_read(input logic [1:0] a);
    address = a;
    read    = 1'b1;
    step();
  endtask

  task automatic reg_write(input logic [31:0] d);
    address   = 2'd2;
    writedata = d;
    write     = 1'b1;
    step();
  endtask

  // Assert reset mid-cycle; outputs must clear without waiting for an edge.
  task automatic do_reset();
    #2 reset = 1'b1;
    #1;
    check("rst_ready", 32'(src_ready), 32'h0);
    check("rst_readdata", readdata, 32'h0);
    check("rst_irq", 32'(irq), 32'h0);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    model_reset();
    src_valid = 4'hF;
    #1;
    do_reset();
    src_valid = '0;

    // Single word from src0 through DATA/STATUS, irq rises then falls.
    reg_write(32'h0000_010F);
    src_data[31:0] = 32'hA000_0001;
    src_valid      = 4'b0001;
    #1 check("t1_ready0", 32'(src_ready), 32'h1);
    step();
    src_valid = '0;
    reg_read(2'd1);
    check("t1_status", readdata, 32'h0000_0010);
    check("t1_irq_hi", 32'(irq), 32'h1);
    reg_read(2'd0);
    check("t1_data", readdata, 32'hA000_0001);
    reg_read(2'd1);
    check("t1_empty", readdata, 32'h0000_0001);
    check("t1_irq_lo", 32'(irq), 32'h0);
    reg_read(2'd2);
    check("t1_ctrl", readdata, 32'h0000_010F);

    // All sources valid from reset: grants 0,1,2,3 then stall on full.
    do_reset();
    reg_write(32'h0000_000F);
    src_valid = 4'hF;
    for (int c = 0; c < 6; c++) begin
      fresh_data();
      step();
    end
    reg_read(2'd1);
    check("t2_full", readdata, 32'h0000_0042);
    // Pop while full: no grant this cycle, source 0 wins next.
    reg_read(2'd0);
    check("t2_head_src0", readdata[31:24], 32'hC0);
    check("t2_ready_after_pop", 32'(src_ready), 32'h1);
    step();
    src_valid = '0;
    for (int c = 0; c < 5; c++) reg_read(2'd0);
    check("t2_drained", readdata, 32'h0);

    // Empty DATA read with a simultaneous push: no fall-through.
    fresh_data();
    src_valid = 4'b0010;
    address   = 2'd0;
    read      = 1'b1;
    step();
    check("t3_empty_read", readdata, 32'h0);
    src_valid = '0;
    reg_read(2'd1);
    check("t3_status", readdata, 32'h0000_0110);
    reg_read(2'd0);

    // Mask only src2, then clear the mask mid-stream.
    reg_write(32'h0000_0104);
    src_valid = 4'hF;
    for (int c = 0; c < 2; c++) begin
      fresh_data();
      step();
    end
    reg_write(32'h0000_0000);
    for (int c = 0; c < 3; c++) begin
      fresh_data();
      step();
    end
    check("t4_no_grant", 32'(src_ready), 32'h0);
    src_valid = '0;
    for (int c = 0; c < 4; c++) reg_read(2'd0);

    // Randomised traffic against the scoreboard.
    reg_write(32'h0000_010F);
    for (int c = 0; c < 200; c++) begin
      fresh_data();
      src_valid = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 2) != 0) begin
        address = ($urandom_range(0, 3) == 0) ? 2'd1 : 2'd0;
        read    = 1'b1;
      end
      step();
    end

    // Reset with three words queued; src0 first after release.
    src_valid = '0;
    for (int c = 0; c < 6; c++) reg_read(2'd0);
    src_valid = 4'hF;
    for (int c = 0; c < 3; c++) begin
      fresh_data();
      step();
    end
    do_reset();
    reg_read(2'd1);
    check("t5_status", readdata, 32'h0000_0001);
    reg_write(32'h0000_010F);
    check("t5_first_src0", 32'(src_ready), 32'h1);
    step();
    src_valid = '0;
    reg_read(2'd1);
    check("t5_count1", readdata, 32'h0000_0010);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
